// File: rtl/spatz_pkg.sv
// Shared Spatz types and constants used by the VFU response collector.
package spatz_pkg;

  localparam int unsigned ELEN                   = 32;
  localparam int unsigned NrParallelInstructions = 4;

  typedef logic [ELEN-1:0]                           elen_t;
  typedef logic [$clog2(NrParallelInstructions)-1:0] spatz_id_t;

  // One VFU completion: instruction id, destination register, writeback flag, scalar result
  typedef struct packed {
    spatz_id_t  id;
    logic [4:0] rd;
    logic       wb;
    elen_t      result;
  } vfu_rsp_t;

  localparam int unsigned VfuRspDepth = 4;

  typedef logic [$clog2(VfuRspDepth+1)-1:0] vfu_rsp_cnt_t;

endpackage

// File: rtl/spatz_rsp_fifo.sv
// Pointer/count FIFO of VFU responses with a head peek, a pop, and a view
// of every stored entry so the parent can build its pending-id mask.
module spatz_rsp_fifo
  import spatz_pkg::*;
#(
  parameter int unsigned Depth = VfuRspDepth
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  vfu_rsp_t               data_i,
  input  logic                   pop_i,
  output vfu_rsp_t               head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output vfu_rsp_t [Depth-1:0]   entries_o,
  output logic     [Depth-1:0]   valid_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth+1);

  vfu_rsp_t [Depth-1:0] mem_q;
  logic     [Depth-1:0] valid_q;
  logic     [PtrW-1:0]  rptr_q;
  logic     [PtrW-1:0]  wptr_q;
  logic     [CntW-1:0]  count_q;
  logic                 do_push;
  logic                 do_pop;

  assign full_o    = (count_q == CntW'(Depth));
  assign empty_o   = (count_q == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign head_o    = mem_q[rptr_q];
  assign entries_o = mem_q;
  assign valid_o   = valid_q;

  // Storage, per-entry valid bits, wrapping pointers and occupancy count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q   <= '0;
      valid_q <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_pop) begin
        valid_q[rptr_q] <= 1'b0;
        rptr_q          <= rptr_q + PtrW'(1);
      end
      if (do_push) begin
        mem_q[wptr_q]   <= data_i;
        valid_q[wptr_q] <= 1'b1;
        wptr_q          <= wptr_q + PtrW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spatz_vfu_rsp_collector.sv
// Collects in-order VFU completions, retires their ids to the scoreboard and
// forwards scalar writebacks to the core over a valid/ready handshake.
// Optional macro SPATZ_VFU_RSP_BYPASS_EN lets a response arriving at an empty
// collector act as the head in the same cycle.
module spatz_vfu_rsp_collector
  import spatz_pkg::*;
#(
  parameter int unsigned Depth = VfuRspDepth,
  parameter int unsigned NrIds = NrParallelInstructions
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             vfu_rsp_valid_i,
  output logic             vfu_rsp_ready_o,
  input  vfu_rsp_t         vfu_rsp_i,
  output logic             xrsp_valid_o,
  input  logic             xrsp_ready_i,
  output logic [4:0]       xrsp_rd_o,
  output logic [ELEN-1:0]  xrsp_data_o,
  output logic             retire_valid_o,
  output spatz_id_t        retire_id_o,
  output logic [NrIds-1:0] pending_o,
  output logic             empty_o
);

  vfu_rsp_t             fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  vfu_rsp_t [Depth-1:0] fifo_entries;
  logic     [Depth-1:0] fifo_valid;

  logic     push_hs;
  logic     bypass;
  vfu_rsp_t head;
  logic     head_valid;
  logic     pop;
  logic     fifo_push;
  logic     fifo_pop;

  // Ready depends only on occupancy, never on the core side, so no comb path from xrsp_ready_i
  assign vfu_rsp_ready_o = !fifo_full && !rst_i;
  assign push_hs         = vfu_rsp_valid_i && vfu_rsp_ready_o;
  assign empty_o         = fifo_empty;

  spatz_rsp_fifo #(
    .Depth (Depth)
  ) i_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (fifo_push),
    .data_i    (vfu_rsp_i),
    .pop_i     (fifo_pop),
    .head_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .entries_o (fifo_entries),
    .valid_o   (fifo_valid)
  );

  // Pick the head (stored or bypassed), decide whether it pops, and whether the input gets stored
  always_comb begin
    bypass = 1'b0;
`ifdef SPATZ_VFU_RSP_BYPASS_EN
    bypass = fifo_empty && push_hs;
`endif
    head       = bypass ? vfu_rsp_i : fifo_head;
    head_valid = !fifo_empty || bypass;
    pop        = head_valid && (!head.wb || xrsp_ready_i);
    fifo_pop   = pop && !fifo_empty;
    fifo_push  = push_hs && !(bypass && pop);
  end

  // Drive the core writeback and retire ports from the head, zero when idle
  always_comb begin
    xrsp_valid_o   = 1'b0;
    xrsp_rd_o      = '0;
    xrsp_data_o    = '0;
    retire_valid_o = 1'b0;
    retire_id_o    = '0;
    if (head_valid && head.wb) begin
      xrsp_valid_o = 1'b1;
      xrsp_rd_o    = head.rd;
      xrsp_data_o  = head.result;
    end
    if (pop) begin
      retire_valid_o = 1'b1;
      retire_id_o    = head.id;
    end
  end

  // One-hot OR of the ids of every stored entry
  always_comb begin
    pending_o = '0;
    for (int i = 0; i < Depth; i++) begin
      if (fifo_valid[i]) begin
        pending_o[fifo_entries[i].id] = 1'b1;
      end
    end
  end

  push_unique_id: assert property (
    @(posedge clk_i) disable iff (rst_i) push_hs |-> !pending_o[vfu_rsp_i.id]
  );

endmodule

// File: tb/tb_spatz_vfu_rsp_collector.sv
// Directed bench for spatz_vfu_rsp_collector: inputs change on the falling
// edge and outputs are checked 1ns later, well away from the rising edge.
module tb_spatz_vfu_rsp_collector;
  import spatz_pkg::*;

`ifdef SPATZ_VFU_RSP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            vfu_rsp_valid;
  logic            vfu_rsp_ready;
  vfu_rsp_t        vfu_rsp;
  logic            xrsp_valid;
  logic            xrsp_ready;
  logic [4:0]      xrsp_rd;
  logic [ELEN-1:0] xrsp_data;
  logic            retire_valid;
  spatz_id_t       retire_id;
  logic [3:0]      pending;
  logic            empty;

  int checks   = 0;
  int failures = 0;

  spatz_vfu_rsp_collector dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .vfu_rsp_valid_i (vfu_rsp_valid),
    .vfu_rsp_ready_o (vfu_rsp_ready),
    .vfu_rsp_i       (vfu_rsp),
    .xrsp_valid_o    (xrsp_valid),
    .xrsp_ready_i    (xrsp_ready),
    .xrsp_rd_o       (xrsp_rd),
    .xrsp_data_o     (xrsp_data),
    .retire_valid_o  (retire_valid),
    .retire_id_o     (retire_id),
    .pending_o       (pending),
    .empty_o         (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs on the falling edge, then let comb outputs settle
  task automatic applyStimulus(input logic v, input int id, input int rd, input logic wb,
                               input logic [31:0] res, input logic xr);
    @(negedge clk);
    vfu_rsp_valid  = v;
    vfu_rsp.id     = spatz_id_t'(id);
    vfu_rsp.rd     = 5'(rd);
    vfu_rsp.wb     = wb;
    vfu_rsp.result = res;
    xrsp_ready     = xr;
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  int ret_ids[$];
  int handshakes;
  logic [4:0]  hs_rd;
  logic [31:0] hs_data;

  initial begin
    rst           = 1'b1;
    vfu_rsp_valid = 1'b0;
    vfu_rsp       = '0;
    xrsp_ready    = 1'b0;

    // ---- reset state ----
    applyStimulus(1'b0, 0, 0, 1'b0, 32'h0, 1'b0);
    checkOutput("rst_ready",   vfu_rsp_ready, 0);
    checkOutput("rst_empty",   empty, 1);
    checkOutput("rst_xvalid",  xrsp_valid, 0);
    checkOutput("rst_retire",  retire_valid, 0);
    checkOutput("rst_ret_id",  retire_id, 0);
    checkOutput("rst_rd",      xrsp_rd, 0);
    checkOutput("rst_data",    xrsp_data, 0);
    checkOutput("rst_pending", pending, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rel_ready", vfu_rsp_ready, 1);

    // ---- single wb=0 response, id 2 ----
    applyStimulus(1'b1, 2, 0, 1'b0, 32'h0, 1'b0);
    checkOutput("s0_retire",  retire_valid, BYP);
    checkOutput("s0_ret_id",  retire_id, BYP ? 2 : 0);
    checkOutput("s0_pending", pending, 0);
    checkOutput("s0_empty",   empty, 1);
    applyStimulus(1'b0, 0, 0, 1'b0, 32'h0, 1'b0);
    checkOutput("s1_retire",  retire_valid, !BYP);
    checkOutput("s1_ret_id",  retire_id, BYP ? 0 : 2);
    checkOutput("s1_xvalid",  xrsp_valid, 0);
    checkOutput("s1_pending", pending, BYP ? 4'b0000 : 4'b0100);
    applyStimulus(1'b0, 0, 0, 1'b0, 32'h0, 1'b0);
    checkOutput("s2_retire",  retire_valid, 0);
    checkOutput("s2_pending", pending, 0);
    checkOutput("s2_empty",   empty, 1);

    // ---- writeback with core stall ----
    applyStimulus(1'b1, 1, 10, 1'b1, 32'hDEADBEEF, 1'b0);
    checkOutput("wb_push_xvalid", xrsp_valid, BYP);
    checkOutput("wb_push_retire", retire_valid, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 0, 0, 1'b0, 32'h0, 1'b0);
      checkOutput("wb_stall_xvalid",  xrsp_valid, 1);
      checkOutput("wb_stall_rd",      xrsp_rd, 10);
      checkOutput("wb_stall_data",    xrsp_data, 32'hDEADBEEF);
      checkOutput("wb_stall_retire",  retire_valid, 0);
      checkOutput("wb_stall_pending", pending, 4'b0010);
    end
    applyStimulus(1'b0, 0, 0, 1'b0, 32'h0, 1'b1);
    checkOutput("wb_hs_xvalid", xrsp_valid, 1);
    checkOutput("wb_hs_retire", retire_valid, 1);
    checkOutput("wb_hs_ret_id", retire_id, 1);
    applyStimulus(1'b0, 0, 0, 1'b0, 32'h0, 1'b0);
    checkOutput("wb_done_xvalid", xrsp_valid, 0);
    checkOutput("wb_done_data",   xrsp_data, 0);
    checkOutput("wb_done_empty",  empty, 1);

    // ---- fill to capacity, then drain ----
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, i, i + 1, 1'b1, 32'h100 + 32'(i), 1'b0);
      checkOutput("fill_ready", vfu_rsp_ready, 1);
    end
    applyStimulus(1'b1, 0, 5, 1'b1, 32'h200, 1'b0);
    checkOutput("full_ready",   vfu_rsp_ready, 0);
    checkOutput("full_pending", pending, 4'b1111);
    checkOutput("full_rd",      xrsp_rd, 1);
    checkOutput("full_data",    xrsp_data, 32'h100);
    applyStimulus(1'b1, 0, 5, 1'b1, 32'h200, 1'b1);
    checkOutput("drain0_ready",  vfu_rsp_ready, 0);
    checkOutput("drain0_retire", retire_valid, 1);
    checkOutput("drain0_ret_id", retire_id, 0);
    applyStimulus(1'b1, 0, 5, 1'b1, 32'h200, 1'b1);
    checkOutput("drain1_ready",   vfu_rsp_ready, 1);
    checkOutput("drain1_ret_id",  retire_id, 1);
    checkOutput("drain1_pending", pending, 4'b1110);
    applyStimulus(1'b0, 0, 0, 1'b0, 32'h0, 1'b1);
    checkOutput("drain2_ret_id",  retire_id, 2);
    checkOutput("drain2_pending", pending, 4'b1101);
    applyStimulus(1'b0, 0, 0, 1'b0, 32'h0, 1'b1);
    checkOutput("drain3_ret_id", retire_id, 3);
    checkOutput("drain3_data",   xrsp_data, 32'h103);
    applyStimulus(1'b0, 0, 0, 1'b0, 32'h0, 1'b1);
    checkOutput("drain4_retire", retire_valid, 1);
    checkOutput("drain4_ret_id", retire_id, 0);
    checkOutput("drain4_rd",     xrsp_rd, 5);
    checkOutput("drain4_data",   xrsp_data, 32'h200);
    applyStimulus(1'b0, 0, 0, 1'b0, 32'h0, 1'b0);
    checkOutput("drain5_empty",  empty, 1);
    checkOutput("drain5_retire", retire_valid, 0);

    // ---- mixed stream with toggling core ready ----
    handshakes = 0;
    hs_rd      = '0;
    hs_data    = '0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(i < 3, i % 4, (i == 1) ? 7 : 0, i == 1,
                    (i == 1) ? 32'h12345678 : 32'h0, 1'(i % 2));
      if (retire_valid) ret_ids.push_back(int'(retire_id));
      if (xrsp_valid && xrsp_ready) begin
        handshakes++;
        hs_rd   = xrsp_rd;
        hs_data = xrsp_data;
      end
    end
    checkOutput("mix_retires", ret_ids.size(), 3);
    checkOutput("mix_order0", (ret_ids.size() > 0) ? ret_ids[0] : -1, 0);
    checkOutput("mix_order1", (ret_ids.size() > 1) ? ret_ids[1] : -1, 1);
    checkOutput("mix_order2", (ret_ids.size() > 2) ? ret_ids[2] : -1, 2);
    checkOutput("mix_handshakes", handshakes, 1);
    checkOutput("mix_rd",   hs_rd, 7);
    checkOutput("mix_data", hs_data, 32'h12345678);
    checkOutput("mix_empty", empty, 1);

    // ---- empty collector, wb=0 id 3 (same-cycle retire only with bypass) ----
    applyStimulus(1'b1, 3, 0, 1'b0, 32'h0, 1'b0);
    checkOutput("byp_retire", retire_valid, BYP);
    checkOutput("byp_ret_id", retire_id, BYP ? 3 : 0);
    checkOutput("byp_empty",  empty, 1);
    applyStimulus(1'b0, 0, 0, 1'b0, 32'h0, 1'b0);
    checkOutput("byp_next_retire", retire_valid, !BYP);
    checkOutput("byp_next_ret_id", retire_id, BYP ? 0 : 3);

    // ---- reset mid-operation with 3 stored entries ----
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, i, i + 20, 1'b1, 32'h300 + 32'(i), 1'b0);
    end
    applyStimulus(1'b0, 0, 0, 1'b0, 32'h0, 1'b0);
    checkOutput("mid_pending", pending, 4'b0111);
    checkOutput("mid_empty",   empty, 0);
    checkOutput("mid_rd",      xrsp_rd, 20);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_empty",   empty, 1);
    checkOutput("mid_rst_pending", pending, 0);
    checkOutput("mid_rst_retire",  retire_valid, 0);
    checkOutput("mid_rst_xvalid",  xrsp_valid, 0);
    checkOutput("mid_rst_ready",   vfu_rsp_ready, 0);
    applyStimulus(1'b0, 0, 0, 1'b0, 32'h0, 1'b1);
    checkOutput("mid_hold_retire", retire_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid_rel_ready",  vfu_rsp_ready, 1);
    checkOutput("mid_rel_empty",  empty, 1);
    checkOutput("mid_rel_retire", retire_valid, 0);
    applyStimulus(1'b0, 0, 0, 1'b0, 32'h0, 1'b1);
    checkOutput("mid_after_retire", retire_valid, 0);
    checkOutput("mid_after_xvalid", xrsp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spatz_vfu_rsp_collector.md
Name: spatz_vfu_rsp_collector

Overview:
- Sits directly downstream of the VFU response port.
- Buffers in-order VFU completion responses (id, rd, wb flag, scalar result) in a small FIFO.
- Retires instruction ids back to the controller's scoreboard.
- Forwards scalar writebacks (wb=1) to the core's accelerator result channel over a valid/ready handshake. Responses with wb=0 retire without involving the core.

Parameters:
- Depth, 4, FIFO entries; power of two, >= 2.
- NrIds, NrParallelInstructions (spatz_pkg), number of distinct instruction ids; width of pending_o.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- vfu_rsp_valid_i  in  1  VFU response valid.
- vfu_rsp_ready_o  out  1  collector can accept a response.
- vfu_rsp_i  in  vfu_rsp_t  {id, rd, wb, result}.
- xrsp_valid_o  out  1  scalar writeback valid towards core.
- xrsp_ready_i  in  1  core accepts writeback.
- xrsp_rd_o  out  5  destination integer register.
- xrsp_data_o  out  ELEN  scalar result.
- retire_valid_o  out  1  one-cycle pulse: an instruction id is retired.
- retire_id_o  out  spatz_id_t  retired id.
- pending_o  out  NrIds  bit i set while any stored entry carries id i.
- empty_o  out  1  FIFO empty.

Behaviour:
- Reset (async, rst_i=1):
  - All entries invalid; read/write pointers and count = 0.
  - Outputs: vfu_rsp_ready_o=1 once reset deasserts (0 while asserted); xrsp_valid_o=0; retire_valid_o=0; retire_id_o=0; xrsp_rd_o=0; xrsp_data_o=0; pending_o=0; empty_o=1.
  - Reset mid-operation discards all entries; no retire pulse is emitted for them.
- Push:
  - vfu_rsp_ready_o = !full. There is no combinational path from xrsp_ready_i.
  - A push occurs on vfu_rsp_valid_i && vfu_rsp_ready_o. The entry is stored at wptr and wptr increments, wrapping modulo Depth.
- Head processing, in order only:
  - Head wb=1: xrsp_valid_o=1, xrsp_rd_o/xrsp_data_o driven from the head entry. Pop on xrsp_ready_i.
  - Head wb=0: pop unconditionally in the first cycle it is at the head. xrsp_valid_o stays 0.
  - On every pop: retire_valid_o=1 and retire_id_o=head.id in the same cycle; rptr increments with wrap.
- Output stability: xrsp_valid_o, once high, holds with stable rd/data until the handshake completes.
- Latency: a response pushed in cycle N is visible at the head in cycle N+1 at the earliest. Throughput is one pop per cycle.
- Count:
  - Width $clog2(Depth+1); push-only +1, pop-only -1, both cases unchanged.
  - full = (count==Depth); empty_o = (count==0).
- Boundaries:
  - Full with a pop in the same cycle: push is still refused that cycle (ready was low).
  - Empty with a push: no pop that cycle.
  - Simultaneous push and pop when count=1: count stays 1 and the new entry becomes the head next cycle.
- pending_o: combinational OR over valid entries of onehot(id).
- Assertions:
  - A push whose id is already set in pending_o is an error (assertion).
  - wb=1 with rd=0 is legal and forwarded unchanged.

Optional Feature:
- Macro: SPATZ_VFU_RSP_BYPASS_EN.
- Defined: when the FIFO is empty, an incoming response is presented at the head in the same cycle.
  - wb=0: it retires combinationally.
  - wb=1 with xrsp_ready_i=1: it completes without being stored; with xrsp_ready_i=0 it is stored and held.
  - The retire/xrsp latency is then 0 cycles.
- Undefined: no bypass; latency is at least 1 cycle as described above.

Decomposition:
- spatz_pkg gets:
  - vfu_rsp_t, which already exists (reuse unchanged);
  - a new constant VfuRspDepth=4;
  - typedef vfu_rsp_cnt_t = logic [$clog2(VfuRspDepth+1)-1:0].
- Sub-module spatz_rsp_fifo: generic pointer/count FIFO of vfu_rsp_t exposing a head peek and a pop.
- The collector adds head classification, the bypass, retire generation and pending_o.

Test Plan:
- Reset mid-operation: 3 entries stored, assert rst_i -> empty_o=1, pending_o=0, no retire pulse, ready=1 after release.
- Single response, wb=0: push id=2 -> next cycle retire_valid_o=1, retire_id_o=2, xrsp_valid_o=0; pending_o[2] set for exactly 1 cycle.
- Writeback with core stall: push {id=1, rd=10, wb=1, result=32'hDEADBEEF}, xrsp_ready_i=0 for 5 cycles -> xrsp_valid_o held with stable rd/data; on ready, retire id=1 in that cycle.
- Fill to capacity: push ids 0..3 with wb=1, ready low -> vfu_rsp_ready_o=0 after the 4th push; a 5th valid is held. Release ready -> in-order retires 0,1,2,3, then the 5th is accepted.
- Mixed stream: ids 0(wb=0), 1(wb=1), 2(wb=0), xrsp_ready_i toggling every cycle -> retire order 0,1,2; exactly one xrsp handshake, rd/data match id 1.
- Bypass, SPATZ_VFU_RSP_BYPASS_EN defined, FIFO empty: push wb=0 id=3 -> retire_valid_o=1, retire_id_o=3 in the same cycle, empty_o stays 1.
